// File: rtl/uart_resp_framer.sv
// uart_resp_framer: serialises PONG/INFO/INVALID/ACK responses and golden
// nonces into a byte stream for the UART transmitter. Nonces are buffered in a
// small FIFO so they survive while another message is being sent.
//
// Byte handshake (tx side): a byte moves when tx_valid && tx_ready are both
// high on a rising edge; while tx_valid is high and tx_ready is low, tx_data
// holds its value. The request side uses the same rule with cmd_valid and
// cmd_ready, and the requester holds cmd_valid/cmd_type until accepted.
module uart_resp_framer #(
  parameter logic [31:0] INFO_WORD0       = 32'hDEADBEEF,
  parameter logic [31:0] INFO_WORD1       = 32'h13370D13,
  parameter int          NONCE_FIFO_DEPTH = 4
) (
  input  logic        comm_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_type,
  output logic        cmd_ready,
  input  logic        nonce_valid,
  input  logic [31:0] nonce,
  output logic        nonce_dropped,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam int PTR_W = (NONCE_FIFO_DEPTH > 1) ? $clog2(NONCE_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(NONCE_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NONCE_FIFO_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  // Latched message kind; the low two bits match cmd_type encoding.
  typedef enum logic [2:0] {
    M_PONG    = 3'd0,
    M_INFO    = 3'd1,
    M_INVALID = 3'd2,
    M_ACK     = 3'd3,
    M_NONCE   = 3'd4
  } msg_e;

  // Select byte 0..3 of a word, byte 0 being the most significant.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Byte at position idx of a message; positions not listed are zero.
  function automatic logic [7:0] msg_byte(input msg_e t, input logic [31:0] n,
                                          input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (t)
      M_PONG, M_ACK: b = 8'h01;
      M_INVALID: begin
        if (idx == 4'd0)      b = 8'h08;
        else if (idx == 4'd3) b = 8'h01;
      end
      M_INFO: begin
        if (idx == 4'd0)            b = 8'h10;
        else if (idx[3:2] == 2'd1)  b = word_byte(INFO_WORD0, idx[1:0]);
        else if (idx[3:2] == 2'd2)  b = word_byte(INFO_WORD1, idx[1:0]);
      end
      M_NONCE: begin
        if (idx == 4'd0)            b = 8'h08;
        else if (idx == 4'd3)       b = 8'h03;
        else if (idx[3:2] == 2'd1)  b = word_byte(n, idx[1:0]);
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Index of the final byte of each message (length minus one).
  function automatic logic [3:0] last_idx(input msg_e t);
    logic [3:0] l;
    case (t)
      M_INFO:            l = 4'd15;
      M_INVALID, M_NONCE: l = 4'd7;
      default:           l = 4'd0;
    endcase
    return l;
  endfunction

  state_e      state_q, state_d;
  msg_e        msg_q, msg_d;
  logic [31:0] nonce_q, nonce_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        drop_q, drop_d;

  logic [31:0]      mem_q [NONCE_FIFO_DEPTH];
  logic [31:0]      mem_d [NONCE_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   take_cmd;
  logic   fifo_nonempty;
  logic   fifo_full;
  logic   fifo_pop;
  logic   fifo_push;
  logic   tx_fire;
  logic   last_byte;
  msg_e   cmd_msg;

  // Control decode: arbitration in IDLE (command beats nonce), byte handshakes in SEND.
  always_comb begin
    cmd_msg       = msg_e'({1'b0, cmd_type});
    fifo_nonempty = (count_q != '0);
    fifo_full     = (count_q == FULL_CNT);
    take_cmd      = (state_q == S_IDLE) && cmd_valid;
    fifo_pop      = (state_q == S_IDLE) && !cmd_valid && fifo_nonempty;
    fifo_push     = nonce_valid && (!fifo_full || fifo_pop);
    tx_fire       = (state_q == S_SEND) && tx_ready;
    last_byte     = (idx_q == last_idx(msg_q));
  end

  // State register.
  always_ff @(posedge comm_clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: leave IDLE on any work, return after the final byte moves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid || fifo_nonempty) state_d = S_SEND;
      S_SEND:  if (tx_fire && last_byte) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; cmd_ready is held low while reset is asserted.
  always_comb begin
    cmd_ready     = (state_q == S_IDLE) && !reset;
    tx_valid      = (state_q == S_SEND);
    busy          = (state_q == S_SEND) || fifo_nonempty;
    tx_data       = tx_data_q;
    nonce_dropped = drop_q;
  end

  // Message latch and byte pipeline: tx_data is preloaded with the next byte
  // so it is valid the cycle after acceptance and after each handshake.
  always_comb begin
    msg_d     = msg_q;
    nonce_d   = nonce_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    if (take_cmd) begin
      msg_d     = cmd_msg;
      idx_d     = 4'd0;
      tx_data_d = msg_byte(cmd_msg, 32'h0, 4'd0);
    end else if (fifo_pop) begin
      msg_d     = M_NONCE;
      nonce_d   = mem_q[rd_ptr_q];
      idx_d     = 4'd0;
      tx_data_d = msg_byte(M_NONCE, mem_q[rd_ptr_q], 4'd0);
    end else if (tx_fire) begin
      if (last_byte) begin
        idx_d     = 4'd0;
        tx_data_d = 8'h00;
      end else begin
        idx_d     = idx_q + 4'd1;
        tx_data_d = msg_byte(msg_q, nonce_q, idx_q + 4'd1);
      end
    end
  end

  // Nonce FIFO bookkeeping; a pop frees the slot a same-cycle push may use.
  always_comb begin
    for (int i = 0; i < NONCE_FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = nonce;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (nonce_valid && !fifo_push) drop_d = 1'b1;
  end

  // Datapath and FIFO control registers.
  always_ff @(posedge comm_clk) begin
    if (reset) begin
      msg_q     <= M_PONG;
      nonce_q   <= 32'h0;
      idx_q     <= 4'd0;
      tx_data_q <= 8'h00;
      drop_q    <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      msg_q     <= msg_d;
      nonce_q   <= nonce_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      drop_q    <= drop_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q, so no reset.
  always_ff @(posedge comm_clk) begin
    for (int i = 0; i < NONCE_FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: doc/uart_resp_framer.md
Name: uart_resp_framer

Overview:
- Device-side response encoder for the miner's UART command protocol; the transmit counterpart of the host command stream.
- Accepts response requests from the command decoder (PONG, INFO, INVALID, ACK) and golden nonces from the hashing core.
- Serialises each message as a byte stream into the UART transmitter through a valid/ready byte handshake.
- Buffers nonces in a small FIFO so that nonces found during an ongoing transmission are not lost.

Parameters:
- INFO_WORD0, 32'hDEADBEEF, first info payload word, sent MSB first.
- INFO_WORD1, 32'h13370D13, second info payload word, sent MSB first.
- NONCE_FIFO_DEPTH, 4, nonce buffer entries; power of two, at least 2.

Ports:
- comm_clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  response request valid.
- cmd_type  in  2  0=PONG, 1=INFO, 2=INVALID, 3=ACK.
- cmd_ready  out  1  request accepted on cmd_valid&cmd_ready.
- nonce_valid  in  1  one-cycle strobe; nonce is pushed into the FIFO.
- nonce  in  32  golden nonce value.
- nonce_dropped  out  1  sticky: a nonce was lost because the FIFO was full.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte on tx_valid&tx_ready.
- busy  out  1  high while a message is in flight or the FIFO is non-empty.

Behaviour:
- Reset values: cmd_ready=0, tx_valid=0, tx_data=0, nonce_dropped=0, busy=0. Reset also clears the FIFO and the byte counter and forces state to IDLE.
- Reset asserted mid-message aborts the message; no further bytes are sent.
- Message formats. Every byte listed counts toward the length byte; there is no CRC on responses.
  - PONG: 1 byte: 01.
  - ACK: 1 byte: 01.
  - INVALID: 8 bytes: 08 00 00 01 00 00 00 00.
  - INFO: 16 bytes: 10 00 00 00, then INFO_WORD0 MSB first, then INFO_WORD1 MSB first, then 00 00 00 00.
  - NONCE: 8 bytes: 08 00 00 03, then the nonce MSB first.
- State machine: IDLE and SEND. The message latch holds the message type plus the 32-bit nonce.
- IDLE:
  - cmd_ready=1, tx_valid=0.
  - If cmd_valid: latch cmd_type, clear the byte index, go to SEND.
  - Otherwise, if the FIFO is non-empty: pop the head into the latch as NONCE, go to SEND.
  - A command wins over a pending nonce in the same cycle.
- SEND:
  - cmd_ready=0, tx_valid=1.
  - tx_data is the byte at the current index of the latched message, registered.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - On a handshake: if index = len-1, go to IDLE; else increment the index.
- Latency: first byte is on tx_valid the cycle after acceptance. Successive bytes can go on consecutive cycles if tx_ready is held high. After the last byte there is at least one IDLE cycle.
- Messages are never interleaved. Arbitration happens only in IDLE.
- cmd_valid is ignored outside IDLE. The decoder holds the request until cmd_ready.
- Nonce FIFO:
  - Push on nonce_valid in any state, including SEND.
  - Pop only in IDLE, when no command is being accepted.
  - Full with a simultaneous pop and push: pop first, then the push is accepted, with no drop.
  - Full with no pop: the nonce is discarded and nonce_dropped is set until reset.
  - Pointers wrap modulo NONCE_FIFO_DEPTH; a separate count distinguishes full from empty.
  - Nonces are emitted in arrival order.
- busy = (state==SEND) | (FIFO count != 0).

Test Plan:
- PONG: cmd_type=0, tx_ready=1 -> exactly one byte 01, tx_valid high for one cycle, back to IDLE; cmd_ready=0 for exactly one cycle.
- INFO with tx_ready toggling 1/0 every other cycle -> 10 00 00 00 DE AD BE EF 13 37 0D 13 00 00 00 00, with tx_data stable while stalled.
- INVALID then ACK back-to-back -> 08 00 00 01 00 00 00 00 then 01; no interleaving.
- Nonce 32'h1DAC2B7C strobed while idle -> 08 00 00 03 1D AC 2B 7C; busy low afterward.
- cmd_valid (INFO) and nonce_valid in the same cycle -> full INFO message first, then the NONCE message.
- During a 16-byte INFO with tx_ready held low, strobe 5 nonces N0..N4 (depth 4) -> nonce_dropped=1; then release tx_ready -> after INFO, four NONCE messages N0..N3 in order; N4 is never sent. Assert reset mid-message -> outputs return to reset values the next cycle and the FIFO is empty.
